// File: rtl/hazard_unit.sv
// Decode-stage RAW hazard detector for the 5-stage core.
// Compares decode sources against EX/MEM destinations, raises load-use
// stall/bubble controls, registers forwarding selects for the next EX
// cycle and keeps a saturating count of stall cycles.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_ex,
  input  logic              we_mem,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [REG_AW-1:0] rs1_dec,
  input  logic [REG_AW-1:0] rs2_dec,
  input  logic              mem_read_ex,
  output logic [3:0]        RAW_hazards,
  output logic              stall_if,
  output logic              stall_dec,
  output logic              flush_ex,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_count
);

  // Forwarding select encoding as seen by the EX operand muxes.
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic              ex_writes;
  logic              mem_writes;
  logic              load_use;
  logic [1:0]        fwd_rs1_sel_d, fwd_rs1_sel_q;
  logic [1:0]        fwd_rs2_sel_d, fwd_rs2_sel_q;
  logic [CNT_W-1:0]  stall_count_d, stall_count_q;

  // A producer only counts if it writes a real register; x0 is hardwired.
  assign ex_writes  = we_ex  && (rd_ex  != '0);
  assign mem_writes = we_mem && (rd_mem != '0);

  // Per-source match flags: {rs2_mem, rs2_ex, rs1_mem, rs1_ex}.
  always_comb begin
    RAW_hazards    = 4'b0000;
    RAW_hazards[0] = ex_writes  && (rd_ex  == rs1_dec);
    RAW_hazards[1] = mem_writes && (rd_mem == rs1_dec);
    RAW_hazards[2] = ex_writes  && (rd_ex  == rs2_dec);
    RAW_hazards[3] = mem_writes && (rd_mem == rs2_dec);
  end

  // A load in EX cannot forward in time: hold IF/DEC and bubble EX.
  assign load_use  = mem_read_ex && (RAW_hazards[0] || RAW_hazards[2]);
  assign stall_if  = load_use;
  assign stall_dec = load_use;
  assign flush_ex  = load_use;

  // Next-cycle forwarding selects; the most recent writer (EX) wins, and a
  // bubble entering EX needs no forwarding at all.
  always_comb begin
    fwd_rs1_sel_d = SEL_RF;
    fwd_rs2_sel_d = SEL_RF;
    if (!load_use) begin
      if (RAW_hazards[0])      fwd_rs1_sel_d = SEL_MEM;
      else if (RAW_hazards[1]) fwd_rs1_sel_d = SEL_WB;
      if (RAW_hazards[2])      fwd_rs2_sel_d = SEL_MEM;
      else if (RAW_hazards[3]) fwd_rs2_sel_d = SEL_WB;
    end
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (load_use && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_rs1_sel_q <= SEL_RF;
      fwd_rs2_sel_q <= SEL_RF;
      stall_count_q <= '0;
    end else begin
      fwd_rs1_sel_q <= fwd_rs1_sel_d;
      fwd_rs2_sel_q <= fwd_rs2_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_rs1_sel = fwd_rs1_sel_q;
  assign fwd_rs2_sel = fwd_rs2_sel_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: hazard flags, load-use controls,
// registered forwarding selects, async reset and counter saturation.
module tb_hazard_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              we_ex;
  logic              we_mem;
  logic [REG_AW-1:0] rd_ex;
  logic [REG_AW-1:0] rd_mem;
  logic [REG_AW-1:0] rs1_dec;
  logic [REG_AW-1:0] rs2_dec;
  logic              mem_read_ex;
  logic [3:0]        RAW_hazards;
  logic              stall_if;
  logic              stall_dec;
  logic              flush_ex;
  logic [1:0]        fwd_rs1_sel;
  logic [1:0]        fwd_rs2_sel;
  logic [CNT_W-1:0]  stall_count;

  int pass_cnt;
  int total_cnt;

  hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_ex       (we_ex),
    .we_mem      (we_mem),
    .rd_ex       (rd_ex),
    .rd_mem      (rd_mem),
    .rs1_dec     (rs1_dec),
    .rs2_dec     (rs2_dec),
    .mem_read_ex (mem_read_ex),
    .RAW_hazards (RAW_hazards),
    .stall_if    (stall_if),
    .stall_dec   (stall_dec),
    .flush_ex    (flush_ex),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .stall_count (stall_count)
  );

  // Clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wex, input logic wmem, input int rdex, input int rdmem,
                       input int r1, input int r2, input logic mrd);
    we_ex       = wex;
    we_mem      = wmem;
    rd_ex       = REG_AW'(rdex);
    rd_mem      = REG_AW'(rdmem);
    rs1_dec     = REG_AW'(r1);
    rs2_dec     = REG_AW'(r2);
    mem_read_ex = mrd;
    #1;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_stall_if"},  32'(stall_if),  32'(exp));
    check({tag, "_stall_dec"}, 32'(stall_dec), 32'(exp));
    check({tag, "_flush_ex"},  32'(flush_ex),  32'(exp));
  endtask

  task automatic check_sel(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    check({tag, "_rs1_sel"}, 32'(fwd_rs1_sel), 32'(e1));
    check({tag, "_rs2_sel"}, 32'(fwd_rs2_sel), 32'(e2));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Reset state.
    #2;
    check_sel("reset", 2'b00, 2'b00);
    check("reset_count", 32'(stall_count), 32'd0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero operands: x0 never hazards.
    drive(1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
    check("zero_hz", 32'(RAW_hazards), 32'h0);
    check_stall("zero", 1'b0);
    tick();
    check_sel("zero", 2'b00, 2'b00);

    // EX hazard on rs1.
    drive(1'b1, 1'b0, 5, 0, 5, 6, 1'b0);
    check("ex_rs1_hz", 32'(RAW_hazards), 32'b0001);
    check_stall("ex_rs1", 1'b0);
    tick();
    check_sel("ex_rs1", 2'b01, 2'b00);

    // Double match: EX wins over MEM on both sources.
    drive(1'b1, 1'b1, 7, 7, 7, 7, 1'b0);
    check("dbl_hz", 32'(RAW_hazards), 32'b1111);
    tick();
    check_sel("dbl", 2'b01, 2'b01);

    // MEM-only hazard on rs2; rd_ex matches too but we_ex is low.
    drive(1'b0, 1'b1, 3, 3, 0, 3, 1'b0);
    check("mem_rs2_hz", 32'(RAW_hazards), 32'b1000);
    tick();
    check_sel("mem_rs2", 2'b00, 2'b10);

    // MEM-only hazard on rs1.
    drive(1'b1, 1'b1, 2, 8, 8, 4, 1'b0);
    check("mem_rs1_hz", 32'(RAW_hazards), 32'b0010);
    tick();
    check_sel("mem_rs1", 2'b10, 2'b00);

    // Load in EX writing x0 is no load-use.
    drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
    check("ld_x0_hz", 32'(RAW_hazards), 32'h0);
    check_stall("ld_x0", 1'b0);
    tick();
    check("ld_x0_count", 32'(stall_count), 32'd0);

    // Set up nonzero selects so the load-use clear is observable.
    drive(1'b1, 1'b1, 9, 11, 11, 9, 1'b0);
    check("pre_ld_hz", 32'(RAW_hazards), 32'b0110);
    tick();
    check_sel("pre_ld", 2'b10, 2'b01);

    // Load-use on rs2.
    drive(1'b1, 1'b0, 9, 0, 1, 9, 1'b1);
    check("ld_hz", 32'(RAW_hazards), 32'b0100);
    check_stall("ld", 1'b1);
    tick();
    check_sel("ld", 2'b00, 2'b00);
    check("ld_count", 32'(stall_count), 32'd1);

    // Load now in MEM, bubble in EX: forward from WB next cycle.
    drive(1'b0, 1'b1, 0, 9, 1, 9, 1'b0);
    check("ld_after_hz", 32'(RAW_hazards), 32'b1000);
    check_stall("ld_after", 1'b0);
    tick();
    check_sel("ld_after", 2'b00, 2'b10);
    check("ld_after_count", 32'(stall_count), 32'd1);

    // Build nonzero state, then assert reset between edges.
    drive(1'b1, 1'b0, 12, 0, 12, 12, 1'b1);
    tick();
    check("pre_rst_count", 32'(stall_count), 32'd2);
    drive(1'b1, 1'b0, 12, 0, 12, 13, 1'b0);
    tick();
    check_sel("pre_rst", 2'b01, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_sel("async_rst", 2'b00, 2'b00);
    check("async_rst_count", 32'(stall_count), 32'd0);
    check("rst_comb_hz", 32'(RAW_hazards), 32'b0001);

    // Release mid-operation; first edge samples inputs normally.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 14, 15, 14, 15, 1'b0);
    check("rel_hz", 32'(RAW_hazards), 32'b1001);
    tick();
    check_sel("rel", 2'b01, 2'b10);
    check("rel_count", 32'(stall_count), 32'd0);

    // Saturation: hold load-use for 2^CNT_W + 3 edges.
    drive(1'b1, 1'b0, 9, 0, 0, 9, 1'b1);
    repeat ((1 << CNT_W) - 2) @(posedge clk);
    #1;
    check("sat_fffe", 32'(stall_count), 32'h0000FFFE);
    tick();
    check("sat_ffff", 32'(stall_count), 32'h0000FFFF);
    repeat (4) @(posedge clk);
    #1;
    check("sat_hold", 32'(stall_count), 32'h0000FFFF);
    check_stall("sat", 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Decode-stage RAW hazard detector for the 5-stage RISC-V core (IF/DEC/EX/MEM/WB). It compares the decode-stage source registers against the destination registers of the instructions in EX and MEM. It reports a per-source hazard vector, raises load-use stall/bubble controls, and registers forwarding selects for the EX stage in the following cycle. A saturating counter tracks stall cycles for performance monitoring.

Parameters:
REG_AW, 5, register-index width (x0..x31)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
we_ex  in  1  instruction in EX writes the register file
we_mem  in  1  instruction in MEM writes the register file
rd_ex  in  REG_AW  destination register of the EX instruction
rd_mem  in  REG_AW  destination register of the MEM instruction
rs1_dec  in  REG_AW  source 1 of the decode instruction
rs2_dec  in  REG_AW  source 2 of the decode instruction
mem_read_ex  in  1  EX instruction is a load
RAW_hazards  out  4  {rs2_mem, rs2_ex, rs1_mem, rs1_ex} match flags
stall_if  out  1  hold PC / IF stage
stall_dec  out  1  hold IF/DEC register
flush_ex  out  1  insert bubble into DEC/EX register
fwd_rs1_sel  out  2  EX operand-1 source: 00 regfile, 01 MEM result, 10 WB result
fwd_rs2_sel  out  2  EX operand-2 source, same encoding
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- RAW_hazards is purely combinational:
  - bit0 = we_ex & (rd_ex != 0) & (rd_ex == rs1_dec)
  - bit1 = we_mem & (rd_mem != 0) & (rd_mem == rs1_dec)
  - bit2 = we_ex & (rd_ex != 0) & (rd_ex == rs2_dec)
  - bit3 = we_mem & (rd_mem != 0) & (rd_mem == rs2_dec)
- x0 never produces a hazard, regardless of the we_* inputs.
- load_use = mem_read_ex & (bit0 | bit2). It is combinational and drives stall_if = stall_dec = flush_ex = load_use.
- Forwarding selects are registered. They are computed in decode and take effect in EX on the next cycle:
  - next rs1 sel = 01 if bit0 (the producer will then be in MEM); else 10 if bit1 (the producer will then be in WB); else 00.
  - EX match takes priority over MEM match (most recent writer wins).
  - rs2 sel uses bit2/bit3 in the same way.
  - When load_use = 1, both selects load 00, because the bubble enters EX.
  - After a stall cycle, the decode instruction is re-evaluated. The load is then in MEM, so a MEM match yields sel 10.
- stall_count increments by 1 on every clk edge where load_use = 1. It saturates at all-ones and never wraps.
- Reset (asynchronous, rst_n low): fwd_rs1_sel = fwd_rs2_sel = 00 and stall_count = 0, immediately and independent of clk. The combinational outputs continue to follow the inputs during reset.
- Reset deasserted mid-operation: the first rising edge after release samples the current inputs normally.
- Unknown or unconnected mem_read_ex must not be relied on. Integrators tie it to 0 when unused.

Test Plan:
- All zero operands: we_ex=1, we_mem=1, rd_ex=rd_mem=rs1_dec=rs2_dec=0 -> RAW_hazards=4'b0000, no stall, selects 00 after the clock.
- EX hazard on rs1: we_ex=1, rd_ex=5, rs1_dec=5, rs2_dec=6, mem_read_ex=0 -> RAW_hazards=4'b0001, no stall; after posedge fwd_rs1_sel=01, fwd_rs2_sel=00.
- Double match, priority: we_ex=we_mem=1, rd_ex=rd_mem=7, rs1_dec=rs2_dec=7 -> RAW_hazards=4'b1111; after posedge both selects = 01.
- MEM-only hazard on rs2: we_ex=0, we_mem=1, rd_mem=3, rs2_dec=3 -> RAW_hazards=4'b1000; after posedge fwd_rs2_sel=10.
- Load-use: mem_read_ex=1, we_ex=1, rd_ex=9, rs2_dec=9 -> stall_if=stall_dec=flush_ex=1, selects 00 after posedge, stall_count=1. Next cycle (load moved: we_mem=1, rd_mem=9, mem_read_ex=0) -> no stall, fwd_rs2_sel=10.
- Reset/saturation:
  - Assert rst_n=0 between edges -> selects and stall_count drop to 0 immediately.
  - Hold load_use=1 for 2^CNT_W+3 cycles -> stall_count stays at 16'hFFFF.
